huff_encoder_param: RTL and testbench
=====================================

HUFF_ENCODER_PARAM -- requirements
Module: huff_encoder_param

Interface
- REQ-001: Parameter NSYM, default 4, maximum symbols per block (legal 2..8).
- REQ-002: Parameter SYM_W, default 8, symbol width in bits.
- REQ-003: Parameter FREQ_W, default 4, per-symbol frequency width in bits.
- REQ-004: Derived widths SHALL be: SUM_W = FREQ_W+$clog2(NSYM); CODE_W = NSYM-1; LEN_W = $clog2(NSYM)+1.
- REQ-005: clk  input  1  single clock; all logic is rising-edge.
- REQ-006: reset  input  1  asynchronous, active-high reset.
- REQ-007: in_valid / in_ready  input / output  1 / 1  load handshake.
- REQ-008: in_sym / in_freq / in_last  input  SYM_W / FREQ_W / 1  symbol, frequency, final symbol of block.
- REQ-009: out_valid / out_ready  output / input  1 / 1  code-table handshake.
- REQ-010: out_sym / out_code / out_len / out_last  output  SYM_W / CODE_W / LEN_W / 1  symbol, right-justified code, code length, final entry.

Function
- REQ-011: FSM states: LOAD, MERGE, ASSIGN, EMIT; transfer on a cycle with valid && ready.
- REQ-012: In LOAD, in_ready=1 and other states in_ready=0; accepted symbols are stored as leaves 0..M-1 in arrival order.
- REQ-013: LOAD SHALL end on a transfer with in_last=1 or the NSYM-th transfer, whichever comes first; M is the accepted count.
- REQ-014: MERGE SHALL perform exactly one merge per cycle for M-1 cycles, creating internal node M-1+k on merge k (k=1..M-1).
- REQ-015: Each merge: min = live node with smallest freq, tie to lowest index; second = same rule over the remaining live nodes; new node freq = sum (SUM_W, no overflow); left child = min, right child = second; both children become dead.
- REQ-016: ASSIGN SHALL visit internal nodes from newest (root) to oldest, one per cycle for M-1 cycles.
- REQ-017: In ASSIGN, root code=0 and len=0; for each child, code = parent code<<1 | bit and len = parent len+1, where bit is 0 for the left child and 1 for the right child.
- REQ-018: When M=1, MERGE and ASSIGN SHALL take zero cycles and leaf 0 SHALL get code 0, len 1.
- REQ-019: Latency: out_valid SHALL first rise exactly 2*(M-1)+1 cycles after the last accepted input; for M=1 it rises 1 cycle after.
- REQ-020: EMIT SHALL present leaves 0..M-1 in load order, advancing one entry per out handshake; out_last=1 only on entry M-1.
- REQ-021: While out_valid=1 and out_ready=0, all out_* outputs SHALL hold stable.
- REQ-022: After the out_last handshake, the FSM SHALL return to LOAD on the next cycle, and in_ready SHALL be 1 in that cycle.
- REQ-023: Zero-frequency symbols SHALL participate as ordinary leaves.
- REQ-024: in_valid asserted outside LOAD SHALL be ignored.

Reset
- REQ-025: Assertion of reset at any time, including mid-MERGE or mid-EMIT, SHALL immediately force state LOAD, M=0, and clear the node pool.
- REQ-026: Output reset values SHALL be: in_ready=1, out_valid=0, out_last=0, out_sym=0, out_code=0, out_len=0.
- REQ-027: After reset deasserts, no partial table from the interrupted block SHALL be emitted.

Configuration
- REQ-028: Macro HUFF_ENC_STATS_EN defined: the block SHALL add output out_total_bits [SUM_W+LEN_W-1:0], equal to sum(freq_i * len_i) over all leaves.
- REQ-029: With HUFF_ENC_STATS_EN defined, out_total_bits SHALL be valid and stable throughout EMIT, and SHALL reset to 0.
- REQ-030: Macro undefined: the port and its logic SHALL be absent; all other behaviour is identical.

Verification (NSYM=4, SYM_W=8, FREQ_W=4)
- REQ-031: Load 0x41/5, 0x42/1, 0x43/1, 0x44/2 with in_last on the 4th symbol -> out_valid rises 7 cycles later. Entries, as (code, len): 0x41 (1, 1); 0x42 (010, 3); 0x43 (011, 3); 0x44 (00, 2). out_last is set on 0x44. With HUFF_ENC_STATS_EN, out_total_bits=15.
- REQ-032: Load four symbols 0x10..0x13, each with freq 1 -> codes 00, 01, 10, 11, all len 2.
- REQ-033: Load a single symbol 0x55/3 with in_last=1 -> out_valid after 1 cycle; code 0, len 1, out_last=1.
- REQ-034: Hold out_ready=0 for 5 cycles during EMIT -> out_* stable and no entry skipped; after the final handshake, in_ready=1 on the next cycle.
- REQ-035: Assert reset during the 2nd MERGE cycle -> in_ready=1 and out_valid=0 immediately. A fresh 2-symbol load of 0x01/1, 0x02/1 then yields 0x01 with code 0 and 0x02 with code 1, both len 1.

Source files
------------

// File: rtl/huff_encoder_param_if.sv
// Load and code-table handshake bundle for huff_encoder_param.
// out_total_bits exists only when HUFF_ENC_STATS_EN is defined.
interface huff_encoder_param_if #(
  parameter int NSYM   = 4,
  parameter int SYM_W  = 8,
  parameter int FREQ_W = 4
);
  localparam int SUM_W  = FREQ_W + $clog2(NSYM);
  localparam int CODE_W = NSYM - 1;
  localparam int LEN_W  = $clog2(NSYM) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [SYM_W-1:0]  in_sym;
  logic [FREQ_W-1:0] in_freq;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [SYM_W-1:0]  out_sym;
  logic [CODE_W-1:0] out_code;
  logic [LEN_W-1:0]  out_len;
  logic              out_last;
`ifdef HUFF_ENC_STATS_EN
  logic [SUM_W+LEN_W-1:0] out_total_bits;

  modport master (
    output in_valid, in_sym, in_freq, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_code,
    input  out_len, out_last, out_total_bits
  );
  modport slave (
    input  in_valid, in_sym, in_freq, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_code,
    output out_len, out_last, out_total_bits
  );
`else
  modport master (
    output in_valid, in_sym, in_freq, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_code,
    input  out_len, out_last
  );
  modport slave (
    input  in_valid, in_sym, in_freq, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_code,
    output out_len, out_last
  );
`endif
endinterface

// File: rtl/huff_encoder_param.sv
// Block Huffman encoder: load leaves, merge, assign codes, emit table.
// Optional HUFF_ENC_STATS_EN adds out_total_bits (sum of freq*len).
module huff_encoder_param #(
  parameter int NSYM   = 4,
  parameter int SYM_W  = 8,
  parameter int FREQ_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  huff_encoder_param_if.slave bus
);
  localparam int SUM_W  = FREQ_W + $clog2(NSYM);
  localparam int CODE_W = NSYM - 1;
  localparam int LEN_W  = $clog2(NSYM) + 1;
  localparam int NN     = 2 * NSYM - 1;
  localparam int IDX_W  = $clog2(2 * NSYM);
  localparam int LIDX_W = $clog2(NSYM);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] MERGE  = 2'd1;
  localparam logic [1:0] ASSIGN = 2'd2;
  localparam logic [1:0] EMIT   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  step_q, step_d;
  logic [SYM_W-1:0]  sym_q [NSYM];
  logic [SYM_W-1:0]  sym_d [NSYM];
  logic [SUM_W-1:0]  freq_q [NN];
  logic [SUM_W-1:0]  freq_d [NN];
  logic [NN-1:0]     live_q, live_d;
  logic [IDX_W-1:0]  left_q [NN];
  logic [IDX_W-1:0]  left_d [NN];
  logic [IDX_W-1:0]  right_q [NN];
  logic [IDX_W-1:0]  right_d [NN];
  logic [CODE_W-1:0] code_q [NN];
  logic [CODE_W-1:0] code_d [NN];
  logic [LEN_W-1:0]  len_q [NN];
  logic [LEN_W-1:0]  len_d [NN];

  logic [IDX_W-1:0]  min1, min2;
  logic              m1v, m2v;
  logic              in_fire, out_fire;
  logic              last_load, emit;
  logic [IDX_W-1:0]  mrg_node, asg_node;
  logic [IDX_W-1:0]  asg_l, asg_r;
  logic [IDX_W-1:0]  cnt_m1, cnt_m2;

  // Two smallest live nodes; strict compare keeps lowest index on ties
  always_comb begin
    min1 = '0;
    min2 = '0;
    m1v  = 1'b0;
    m2v  = 1'b0;
    for (int i = 0; i < NN; i++) begin
      if (live_q[i] &&
          (!m1v || freq_q[i] < freq_q[min1])) begin
        min1 = IDX_W'(i);
        m1v  = 1'b1;
      end
    end
    for (int i = 0; i < NN; i++) begin
      if (live_q[i] && IDX_W'(i) != min1 &&
          (!m2v || freq_q[i] < freq_q[min2])) begin
        min2 = IDX_W'(i);
        m2v  = 1'b1;
      end
    end
  end

  assign emit      = (state_q == EMIT);
  assign in_fire   = bus.in_valid && (state_q == LOAD);
  assign out_fire  = emit && bus.out_ready;
  assign cnt_m1    = cnt_q - IDX_W'(1);
  assign cnt_m2    = cnt_q - IDX_W'(2);
  assign last_load = in_fire &&
                     (bus.in_last || cnt_q == IDX_W'(NSYM - 1));
  assign mrg_node  = cnt_q + step_q;
  // Internal nodes visited root first: 2M-2 down to M
  assign asg_node  = (cnt_q << 1) - IDX_W'(2) - step_q;
  assign asg_l     = left_q[asg_node];
  assign asg_r     = right_q[asg_node];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    sym_d   = sym_q;
    freq_d  = freq_q;
    live_d  = live_q;
    left_d  = left_q;
    right_d = right_q;
    code_d  = code_q;
    len_d   = len_q;
    unique case (1'b1)
      state_q == LOAD: begin
        if (in_fire) begin
          sym_d[cnt_q[LIDX_W-1:0]] = bus.in_sym;
          freq_d[cnt_q] = SUM_W'(bus.in_freq);
          live_d[cnt_q] = 1'b1;
          cnt_d = cnt_q + IDX_W'(1);
          if (last_load) begin
            for (int i = 0; i < NN; i++) begin
              code_d[i] = '0;
              len_d[i]  = '0;
            end
            step_d = '0;
            if (cnt_q == '0) begin
              len_d[0] = LEN_W'(1);
              state_d  = EMIT;
            end else begin
              state_d  = MERGE;
            end
          end
        end
      end
      state_q == MERGE: begin
        freq_d[mrg_node]  = freq_q[min1] + freq_q[min2];
        left_d[mrg_node]  = min1;
        right_d[mrg_node] = min2;
        live_d[mrg_node]  = 1'b1;
        live_d[min1]      = 1'b0;
        live_d[min2]      = 1'b0;
        step_d = step_q + IDX_W'(1);
        if (step_q == cnt_m2) begin
          step_d  = '0;
          state_d = ASSIGN;
        end
      end
      state_q == ASSIGN: begin
        code_d[asg_l] = code_q[asg_node] << 1;
        code_d[asg_r] = (code_q[asg_node] << 1) | CODE_W'(1);
        len_d[asg_l]  = len_q[asg_node] + LEN_W'(1);
        len_d[asg_r]  = len_q[asg_node] + LEN_W'(1);
        step_d = step_q + IDX_W'(1);
        if (step_q == cnt_m2) begin
          step_d  = '0;
          state_d = EMIT;
        end
      end
      state_q == EMIT: begin
        if (out_fire) begin
          step_d = step_q + IDX_W'(1);
          if (step_q == cnt_m1) begin
            step_d  = '0;
            cnt_d   = '0;
            live_d  = '0;
            state_d = LOAD;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      step_q  <= '0;
      live_q  <= '0;
      for (int i = 0; i < NSYM; i++) sym_q[i] <= '0;
      for (int i = 0; i < NN; i++) begin
        freq_q[i]  <= '0;
        left_q[i]  <= '0;
        right_q[i] <= '0;
        code_q[i]  <= '0;
        len_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      live_q  <= live_d;
      sym_q   <= sym_d;
      freq_q  <= freq_d;
      left_q  <= left_d;
      right_q <= right_d;
      code_q  <= code_d;
      len_q   <= len_d;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = emit;
  assign bus.out_sym   = emit ? sym_q[step_q[LIDX_W-1:0]] : '0;
  assign bus.out_code  = emit ? code_q[step_q] : '0;
  assign bus.out_len   = emit ? len_q[step_q] : '0;
  assign bus.out_last  = emit && (step_q == cnt_m1);

`ifdef HUFF_ENC_STATS_EN
  localparam int TOT_W = SUM_W + LEN_W;
  logic [TOT_W-1:0] tot;

  // Only leaves below M count; higher slots may hold internal nodes
  always_comb begin
    tot = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (IDX_W'(i) < cnt_q)
        tot = tot + TOT_W'(freq_q[i]) * TOT_W'(len_q[i]);
    end
  end

  assign bus.out_total_bits = emit ? tot : '0;
`endif
endmodule

// File: tb/tb_huff_encoder_param.sv
// Self-checking bench for huff_encoder_param (NSYM=4, SYM_W=8, FREQ_W=4).
// Expected tables come from a parent-pointer Huffman model walked leaf-up.
module tb_huff_encoder_param;
  localparam int NSYM = 4;
  localparam int NN   = 2 * NSYM - 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  int bsym  [NSYM];
  int bfreq [NSYM];
  int ecode [NSYM];
  int elen  [NSYM];
  int etot;
  bit junk;

  huff_encoder_param_if #(.NSYM(4), .SYM_W(8), .FREQ_W(4)) bus ();

  huff_encoder_param #(.NSYM(4), .SYM_W(8), .FREQ_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build tree with parent pointers, then derive each code leaf-to-root
  task automatic model(input int m);
    int f [NN];
    bit live [NN];
    int par [NN];
    bit isr [NN];
    int a, b, n, node, d, c;
    for (int i = 0; i < NN; i++) begin
      f[i] = 0; live[i] = 0; par[i] = -1; isr[i] = 0;
    end
    for (int i = 0; i < m; i++) begin
      f[i] = bfreq[i];
      live[i] = 1;
    end
    for (int k = 1; k < m; k++) begin
      a = -1; b = -1;
      for (int i = 0; i < NN; i++)
        if (live[i] && (a < 0 || f[i] < f[a])) a = i;
      for (int i = 0; i < NN; i++)
        if (live[i] && i != a && (b < 0 || f[i] < f[b])) b = i;
      n = m - 1 + k;
      f[n] = f[a] + f[b];
      live[n] = 1; live[a] = 0; live[b] = 0;
      par[a] = n; isr[a] = 0;
      par[b] = n; isr[b] = 1;
    end
    etot = 0;
    for (int i = 0; i < m; i++) begin
      if (m == 1) begin
        ecode[i] = 0; elen[i] = 1;
      end else begin
        node = i; d = 0; c = 0;
        while (par[node] >= 0) begin
          c = c | (int'(isr[node]) << d);
          d++;
          node = par[node];
        end
        ecode[i] = c; elen[i] = d;
      end
      etot += bfreq[i] * elen[i];
    end
  endtask

  task automatic load_block(input int m, input bit use_last,
                            input bit gaps, input bit wait_out);
    int lat;
    model(m);
    for (int i = 0; i < m; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      chk("in_ready_load", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_sym   = 8'(bsym[i]);
      bus.in_freq  = 4'(bfreq[i]);
      bus.in_last  = (i == m - 1) && (use_last || m < NSYM);
      tick();
    end
    bus.in_valid = junk;
    bus.in_sym   = 8'($urandom);
    bus.in_last  = 1'($urandom);
    if (!wait_out) return;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, 2 * (m - 1) + 1);
    chk("in_ready_busy", bus.in_ready, 0);
  endtask

  task automatic check_entry(input int i, input int m);
    chk("out_valid", bus.out_valid, 1);
    chk("out_sym", bus.out_sym, bsym[i]);
    chk("out_code", bus.out_code, ecode[i]);
    chk("out_len", bus.out_len, elen[i]);
    chk("out_last", bus.out_last, (i == m - 1));
`ifdef HUFF_ENC_STATS_EN
    chk("out_total_bits", bus.out_total_bits, etot);
`endif
  endtask

  task automatic drain(input int m, input int maxstall,
                       input int fixed_at);
    int stall;
    for (int i = 0; i < m; i++) begin
      stall = (i == fixed_at) ? 5 : $urandom_range(0, maxstall);
      bus.out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        check_entry(i, m);
        tick();
      end
      check_entry(i, m);
      bus.out_ready = 1'b1;
      if (i == m - 1) bus.in_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;
    end
    chk("in_ready_after", bus.in_ready, 1);
    chk("out_valid_after", bus.out_valid, 0);
  endtask

  task automatic set4(input int s0, input int f0, input int s1,
                      input int f1, input int s2, input int f2,
                      input int s3, input int f3);
    bsym[0] = s0; bfreq[0] = f0;
    bsym[1] = s1; bfreq[1] = f1;
    bsym[2] = s2; bfreq[2] = f2;
    bsym[3] = s3; bfreq[3] = f3;
  endtask

  initial begin
    int m;
    checks = 0;
    failures = 0;
    junk = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sym    = '0;
    bus.in_freq   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_sym", bus.out_sym, 0);
    chk("rst_out_code", bus.out_code, 0);
    chk("rst_out_len", bus.out_len, 0);
`ifdef HUFF_ENC_STATS_EN
    chk("rst_total_bits", bus.out_total_bits, 0);
`endif
    reset = 1'b0;
    tick();

    set4(8'h41, 5, 8'h42, 1, 8'h43, 1, 8'h44, 2);
    load_block(4, 1, 0, 1);
    drain(4, 0, -1);

    set4(8'h10, 1, 8'h11, 1, 8'h12, 1, 8'h13, 1);
    load_block(4, 1, 0, 1);
    drain(4, 0, -1);

    set4(8'h55, 3, 0, 0, 0, 0, 0, 0);
    load_block(1, 1, 0, 1);
    drain(1, 0, -1);

    set4(8'h61, 2, 8'h62, 7, 8'h63, 0, 8'h64, 3);
    load_block(4, 1, 0, 1);
    drain(4, 0, 1);

    set4(8'h71, 4, 8'h72, 2, 8'h73, 6, 8'h74, 1);
    load_block(4, 1, 0, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_last", bus.out_last, 0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (8) begin
      tick();
      chk("postrst_idle", bus.out_valid, 0);
    end
    set4(8'h01, 1, 8'h02, 1, 0, 0, 0, 0);
    load_block(2, 1, 0, 1);
    drain(2, 1, -1);

    for (int b = 0; b < 30; b++) begin
      m = $urandom_range(1, NSYM);
      for (int i = 0; i < NSYM; i++) begin
        bsym[i]  = $urandom_range(0, 255);
        bfreq[i] = $urandom_range(0, 15);
      end
      junk = 1'($urandom);
      load_block(m, 1'($urandom), 1, 1);
      drain(m, 3, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
